// File: rtl/fifo_stream_packer.sv
// Packs RATIO consecutive FIFO entries into one wide valid/ready output word.
// Optional partial-word flush with per-lane keep mask: define FIFO_PACKER_FLUSH_EN.
module fifo_stream_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RATIO      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fifo_empty,
  output logic                        fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]       fifo_dout,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH*RATIO-1:0] m_data,
`ifdef FIFO_PACKER_FLUSH_EN
  input  logic                        flush,
  output logic [RATIO-1:0]            m_keep,
`endif
  output logic                        busy
);

  localparam int unsigned CntW  = $clog2(RATIO + 1);
  localparam int unsigned WordW = DATA_WIDTH * RATIO;
  localparam logic [CntW-1:0] CntFull = CntW'(RATIO);

  logic [CntW-1:0]  lane_cnt_q, lane_cnt_d;
  logic             pending_q;
  logic [WordW-1:0] asm_q, asm_d;
  logic [WordW-1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic [RATIO-1:0] m_keep_q, m_keep_d;

  logic [RATIO-1:0] lane_mask;
  logic [WordW-1:0] asm_masked;
  logic             out_free;
  logic             xfer;
  logic             do_xfer;
  logic             room;
  logic             rd_gate;

  assign out_free = !m_valid_q || m_ready;
  assign xfer     = (lane_cnt_q == CntFull) && out_free;
  // Entries already captured plus the one in flight must leave a free lane.
  assign room     = ({1'b0, lane_cnt_q} + {{CntW{1'b0}}, pending_q}) < {1'b0, CntFull};

`ifdef FIFO_PACKER_FLUSH_EN
  logic flush_req_q, flush_req_d;
  logic flush_xfer;

  assign flush_xfer = flush_req_q && !pending_q && (lane_cnt_q != '0) && out_free;
  assign do_xfer    = xfer || flush_xfer;
  assign rd_gate    = !flush_req_q;

  always_comb begin
    flush_req_d = flush_req_q;
    if (flush_req_q && !pending_q && ((lane_cnt_q == '0) || flush_xfer)) begin
      flush_req_d = 1'b0;
    end
    if (flush) begin
      flush_req_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_req_q <= 1'b0;
    end else begin
      flush_req_q <= flush_req_d;
    end
  end

  assign m_keep = m_keep_q;
`else
  assign do_xfer = xfer;
  assign rd_gate = 1'b1;
`endif

  assign fifo_rd_en = !rst && !fifo_empty && rd_gate && (xfer || room);

  // Lanes at or above lane_cnt are stale and are zeroed on the way out.
  always_comb begin
    lane_mask  = '0;
    asm_masked = '0;
    for (int i = 0; i < RATIO; i++) begin
      lane_mask[i] = CntW'(i) < lane_cnt_q;
      if (lane_mask[i]) begin
        asm_masked[i*DATA_WIDTH +: DATA_WIDTH] = asm_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    asm_d = asm_q;
    for (int i = 0; i < RATIO; i++) begin
      if (pending_q && (lane_cnt_q == CntW'(i))) begin
        asm_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_dout;
      end
    end
  end

  always_comb begin
    lane_cnt_d = lane_cnt_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    if (do_xfer) begin
      lane_cnt_d = '0;
      m_valid_d  = 1'b1;
      m_data_d   = asm_masked;
      m_keep_d   = lane_mask;
    end else begin
      if (pending_q) begin
        lane_cnt_d = lane_cnt_q + 1'b1;
      end
      if (m_valid_q && m_ready) begin
        m_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt_q <= '0;
      pending_q  <= 1'b0;
      asm_q      <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_keep_q   <= '0;
    end else begin
      lane_cnt_q <= lane_cnt_d;
      pending_q  <= fifo_rd_en;
      asm_q      <= asm_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_keep_q   <= m_keep_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign busy    = (lane_cnt_q != '0) || pending_q || m_valid_q;

endmodule

// File: doc/fifo_stream_packer.md
# fifo_stream_packer

Read-side stage placed directly downstream of the synchronous FIFO. It drains DATA_WIDTH-bit entries through the FIFO's `rd_en`/`dout`/`empty` port, which has a 1-cycle registered read. It packs RATIO consecutive entries into one wide word and presents that word on a valid/ready stream toward the consumer. Assembly of the next word continues while the current output word waits under backpressure.

## Interface
- `DATA_WIDTH`, 8, width of one FIFO entry
- `RATIO`, 4, entries per output word, ≥2
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_rd_en`  out  1  read request to FIFO (combinational)
- `fifo_dout`  in  DATA_WIDTH  FIFO read data, valid the cycle after a granted read
- `m_valid`  out  1  output word valid
- `m_ready`  in  1  consumer accepts the word
- `m_data`  out  DATA_WIDTH*RATIO  packed word; first-read entry in bits [DATA_WIDTH-1:0]
- `busy`  out  1  `lane_cnt`≠0, or `pending`, or `m_valid`
- `flush`  in  1  force out a partial word (present only with FIFO_PACKER_FLUSH_EN)
- `m_keep`  out  RATIO  per-lane valid mask (present only with FIFO_PACKER_FLUSH_EN)

## Operation
- **State:**
  - `lane_cnt`, width $clog2(RATIO+1): count of entries captured in the assembly register.
  - `pending`: a read was granted last cycle.
  - Output register: `m_data`, `m_keep`, `m_valid`.
- **Read issue:** `fifo_rd_en` = !rst && !fifo_empty && (xfer || lane_cnt+pending < RATIO).
  - `xfer` = (lane_cnt==RATIO) && (!m_valid || m_ready).
- **Pending:** `pending` <= `fifo_rd_en` each cycle.
- **Capture:** when `pending`=1, `fifo_dout` is written into assembly lane `lane_cnt` and `lane_cnt` increments. The sum `lane_cnt`+`pending` never exceeds RATIO.
- **Transfer:** on `xfer`, the assembly register loads the output register, `m_valid`<=1, and `lane_cnt`<=0. `pending` is always 0 when `xfer` is true, so capture and transfer never collide.
- **Output handshake:**
  - A beat completes on `m_valid && m_ready`.
  - If no transfer happens in the same cycle, `m_valid`<=0 after the beat.
  - While `m_valid && !m_ready`, `m_data` and `m_keep` are held stable.
  - The assembly register keeps filling during a stall. Reads stop once it holds RATIO entries.
- **Sequencing:** there is no separate FSM; `lane_cnt`, `pending` and `m_valid` form the control state.
- **Reset** (any cycle, including mid-word):
  - `m_valid`=0, `m_data`=0, `m_keep`=0, `lane_cnt`=0, `pending`=0, `busy`=0.
  - `fifo_rd_en` is forced 0 during reset.
  - The partial word and any in-flight entry are discarded.
- **Empty FIFO:** no read is issued, and the partial word is held indefinitely unless flushed.

## Timing
- Read latency:
  - `fifo_rd_en` high in cycle n → `fifo_dout` is valid in cycle n+1.
  - The entry is captured at the end of n+1.
- First-word latency: the first `fifo_rd_en` in cycle n → `m_valid` high in cycle n+RATIO+2. For RATIO=4 that is n+6.
- Sustained throughput with `m_ready`=1 and the FIFO non-empty: RATIO entries per RATIO+1 cycles. There is one `fifo_rd_en` bubble per word, in the cycle before `xfer`.
- Backpressure: at most 2 words are resident in the block, 1 in the output register and 1 in assembly.
- Reset takes effect at the first rising edge with `rst`=1. Outputs hold their reset values until the first edge with `rst`=0.

## Configuration
- **FIFO_PACKER_FLUSH_EN defined:**
  - `flush` and `m_keep` ports exist.
  - A `flush` pulse sets `flush_req`. While `flush_req` is set, `fifo_rd_en` is held 0.
  - After `pending` clears: if `lane_cnt`>0, the partial word transfers once the output is free. Unused lanes are 0, and `m_keep` has its low `lane_cnt` bits set. If `lane_cnt`=0, no beat is produced.
  - `flush_req` clears on that transfer, or immediately when `lane_cnt`=0.
  - Full words carry `m_keep`=all ones.
  - `flush` asserted together with `rst` is ignored.
- **FIFO_PACKER_FLUSH_EN not defined:** the `flush` and `m_keep` ports and the flush logic are absent. Only full words are emitted.

## Test plan
- **Reset with data available:** `rst`=1, FIFO holding 3 entries → `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `busy`=0 every cycle of reset.
- **Single word:** push 0x11,0x22,0x33,0x44, `m_ready`=1 → one beat with `m_data`=0x44332211. `m_valid` is high for 1 cycle, 6 cycles after the first `fifo_rd_en`.
- **Streaming:** push 0x01..0x08, `m_ready`=1 → beats 0x04030201 then 0x08070605. `fifo_rd_en` is high for cycles n..n+3, low at n+4, high for n+5..n+8.
- **Backpressure:** push 12 entries, `m_ready`=0 → first word held stable and `fifo_rd_en` stops after 8 reads, leaving the FIFO with 4 entries. Raise `m_ready` → 3 beats in order with no loss.
- **Flush (macro on):** push 0xA1,0xB2,0xC3, then pulse `flush` → `m_data`=0x00C3B2A1, `m_keep`=0b0111, and no further reads while `flush_req` is set.
- **Mid-word reset:** after 2 entries are captured, pulse `rst` and refill the FIFO with 0x55,0x66,0x77,0x88 → first beat is 0x88776655, with no stale lanes.
